// File: rtl/uart_seg_pkg.sv
// Shared types and constants for the UART-fed 7-segment scanner.
// Hex glyphs are used only when UART_SEG_HEX_DIGITS_EN is defined.
package uart_seg_pkg;

  // {blank, value[3:0]}
  typedef logic [4:0] digit_t;
  localparam digit_t DIGIT_BLANK = 5'b10000;

  // Team segment map: bit0=c bit1=d bit2=e bit3=b bit4=a bit5=f bit6=g
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0001001;
  localparam logic [6:0] SEG_2     = 7'b1011110;
  localparam logic [6:0] SEG_3     = 7'b1011011;
  localparam logic [6:0] SEG_4     = 7'b1101001;
  localparam logic [6:0] SEG_5     = 7'b1110011;
  localparam logic [6:0] SEG_6     = 7'b1110111;
  localparam logic [6:0] SEG_7     = 7'b0011001;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_A     = 7'b1111101;
  localparam logic [6:0] SEG_B     = 7'b1100111;
  localparam logic [6:0] SEG_C     = 7'b0110110;
  localparam logic [6:0] SEG_D     = 7'b1001111;
  localparam logic [6:0] SEG_E     = 7'b1110110;
  localparam logic [6:0] SEG_F     = 7'b1110100;

  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_BS = 8'h08;

  typedef enum logic [1:0] {
    BYTE_DIGIT,
    BYTE_BS,
    BYTE_TERM,
    BYTE_OTHER
  } byte_class_t;

  function automatic logic [6:0] seg_lookup(input digit_t d);
    logic [6:0] s;
    s = SEG_BLANK;
    if (!d[4]) begin
      case (d[3:0])
        4'h0: s = SEG_0;
        4'h1: s = SEG_1;
        4'h2: s = SEG_2;
        4'h3: s = SEG_3;
        4'h4: s = SEG_4;
        4'h5: s = SEG_5;
        4'h6: s = SEG_6;
        4'h7: s = SEG_7;
        4'h8: s = SEG_8;
        4'h9: s = SEG_9;
        4'hA: s = SEG_A;
        4'hB: s = SEG_B;
        4'hC: s = SEG_C;
        4'hD: s = SEG_D;
        4'hE: s = SEG_E;
        default: s = SEG_F;
      endcase
    end
    return s;
  endfunction

endpackage

// File: rtl/uart_seg_scanner_if.sv
// Byte-stream input and multiplexed display output bundle.
interface uart_seg_scanner_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic [6:0]            seg;
  logic [NUM_DIGITS-1:0] dig_en;
  logic                  err;

  modport master (output rx_data, rx_valid, input seg, dig_en, err);
  modport slave  (input rx_data, rx_valid, output seg, dig_en, err);
endinterface

// File: rtl/uart_seg_scanner_mux.sv
// Digit scan timer, one-hot digit enable and registered segment lookup.
module seg_scan_mux
  import uart_seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SCAN_DIV   = 27000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  digit_t [NUM_DIGITS-1:0] i_digits,
  output logic [6:0]              o_seg,
  output logic [NUM_DIGITS-1:0]   o_dig_en
);
  localparam int unsigned CW = $clog2(SCAN_DIV);
  localparam int unsigned IW = $clog2(NUM_DIGITS);

  logic [CW-1:0]         r_cnt;
  logic [IW-1:0]         r_idx;
  logic [IW-1:0]         w_idx_next;
  logic                  w_wrap;
  logic [NUM_DIGITS-1:0] w_onehot;
  logic [6:0]            r_seg;
  logic [NUM_DIGITS-1:0] r_dig_en;

  always_comb begin
    w_wrap     = (r_cnt == CW'(SCAN_DIV - 1));
    w_idx_next = r_idx;
    if (w_wrap) begin
      w_idx_next = (r_idx == IW'(NUM_DIGITS - 1)) ? '0 : r_idx + IW'(1);
    end
    w_onehot = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << w_idx_next;
  end

  // seg and dig_en both follow the next index so they always change together
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_idx    <= '0;
      r_dig_en <= {{(NUM_DIGITS-1){1'b0}}, 1'b1};
      r_seg    <= SEG_BLANK;
    end else begin
      r_cnt    <= w_wrap ? '0 : r_cnt + CW'(1);
      r_idx    <= w_idx_next;
      r_dig_en <= w_onehot;
      r_seg    <= seg_lookup(i_digits[w_idx_next]);
    end
  end

  assign o_seg    = r_seg;
  assign o_dig_en = r_dig_en;
endmodule

// File: rtl/uart_seg_scanner.sv
// Parses ASCII digits/BS/CR/LF into an entry buffer and commits it to a scanned display.
// Define UART_SEG_HEX_DIGITS_EN to accept A-F / a-f as hex digit values.
module uart_seg_scanner
  import uart_seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SCAN_DIV   = 27000
) (
  input  logic               clk,
  input  logic               rst,
  uart_seg_scanner_if.slave  bus
);
  localparam int unsigned NW = $clog2(NUM_DIGITS + 1);

  digit_t [NUM_DIGITS-1:0] r_entry;
  digit_t [NUM_DIGITS-1:0] r_disp;
  logic [NW-1:0]           r_count;
  logic                    r_err;
  byte_class_t             w_class;
  logic [3:0]              w_value;

  always_comb begin
    w_class = BYTE_OTHER;
    w_value = '0;
    if (bus.rx_data >= 8'h30 && bus.rx_data <= 8'h39) begin
      w_class = BYTE_DIGIT;
      w_value = bus.rx_data[3:0];
    end else if (bus.rx_data == CH_BS) begin
      w_class = BYTE_BS;
    end else if (bus.rx_data == CH_CR || bus.rx_data == CH_LF) begin
      w_class = BYTE_TERM;
    end
`ifdef UART_SEG_HEX_DIGITS_EN
    else if ((bus.rx_data >= 8'h41 && bus.rx_data <= 8'h46) ||
             (bus.rx_data >= 8'h61 && bus.rx_data <= 8'h66)) begin
      w_class = BYTE_DIGIT;
      w_value = bus.rx_data[3:0] + 4'd9;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_entry <= {NUM_DIGITS{DIGIT_BLANK}};
      r_disp  <= {NUM_DIGITS{DIGIT_BLANK}};
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= bus.rx_valid && (w_class == BYTE_OTHER);
      if (bus.rx_valid) begin
        case (w_class)
          BYTE_DIGIT: begin
            r_entry <= {r_entry[NUM_DIGITS-2:0], {1'b0, w_value}};
            if (r_count != NW'(NUM_DIGITS)) r_count <= r_count + NW'(1);
          end
          BYTE_BS: begin
            if (r_count != '0) begin
              r_entry <= {DIGIT_BLANK, r_entry[NUM_DIGITS-1:1]};
              r_count <= r_count - NW'(1);
            end
          end
          // empty terminator leaves the display alone so CR+LF keeps the value
          BYTE_TERM: begin
            if (r_count != '0) begin
              r_disp  <= r_entry;
              r_entry <= {NUM_DIGITS{DIGIT_BLANK}};
              r_count <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  seg_scan_mux #(
    .NUM_DIGITS (NUM_DIGITS),
    .SCAN_DIV   (SCAN_DIV)
  ) u_mux (
    .clk      (clk),
    .rst      (rst),
    .i_digits (r_disp),
    .o_seg    (bus.seg),
    .o_dig_en (bus.dig_en)
  );

  assign bus.err = r_err;
endmodule
